pool_unit: RTL and testbench

//  Parametrised pooling engine; next generation of the fixed 3x3 max-pool stage.
//  - Reduces WIN signed elements per beat to one result, selectable per beat: max-pool or shift-average.
//  - Pipelined reduction tree; valid/ready handshake with full-pipeline backpressure.
//  - Carries a sideband tag (channel/pixel id) in order alongside the data.
//  - Sits between the conv/activation output and the feature-map writer.

---
 rtl/pool_pkg.sv | 48 ++++
 rtl/pool_tree_level.sv | 65 ++++++
 rtl/pool_unit.sv | 106 ++++++++++
 tb/tb_pool_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling engine: mode encoding, elaboration-time
// sizing helpers for the reduction tree, and the signed saturation helper.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Node count at tree level k (level 0 is the raw window).
    function automatic int lvl_nodes(input int win, input int k);
        return (win + (1 << k) - 1) >> k;
    endfunction

    // Bit offset of level k inside the flattened tree bus.
    function automatic int lvl_off(input int win, input int k, input int iw);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o = o + lvl_nodes(win, j) * iw;
        end
        return o;
    endfunction

    // Clamp a wide signed value into the range of a dw-bit signed number.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pool_tree_level.sv
// One registered level of the pooling reduction tree: pairs nodes with max or
// add, passes an odd leftover node through, and carries valid/mode/tag along.
module pool_tree_level
    import pool_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int IW    = 17,
    parameter int TAG_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en_i,
    input  logic                              vld_i,
    input  logic                              mode_i,
    input  logic [TAG_W-1:0]                  tag_i,
    input  logic [N_IN*IW-1:0]                data_i,
    output logic                              vld_o,
    output logic                              mode_o,
    output logic [TAG_W-1:0]                  tag_o,
    output logic [((N_IN+1)/2)*IW-1:0]        data_o
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*IW-1:0] data_d;
    logic [N_OUT*IW-1:0] data_q;
    logic                vld_q;
    logic                mode_q;
    logic [TAG_W-1:0]    tag_q;

    for (genvar i = 0; i < N_OUT; i++) begin : g_node
        logic signed [IW-1:0] a;
        assign a = data_i[2*i*IW +: IW];
        if (2*i + 1 < N_IN) begin : g_pair
            logic signed [IW-1:0] b;
            assign b = data_i[(2*i+1)*IW +: IW];
            assign data_d[i*IW +: IW] = (mode_i == POOL_AVG) ? (a + b) : ((a > b) ? a : b);
        end else begin : g_pass
            assign data_d[i*IW +: IW] = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (en_i) begin
            vld_q <= vld_i;
        end
    end

    // Payload registers carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (en_i) begin
            data_q <= data_d;
            mode_q <= mode_i;
            tag_q  <= tag_i;
        end
    end

    assign vld_o  = vld_q;
    assign mode_o = mode_q;
    assign tag_o  = tag_q;
    assign data_o = data_q;

endmodule

// File: rtl/pool_unit.sv
// Pipelined WIN-element pooling engine (max or shift-average per beat) with
// an in-order sideband tag and whole-pipeline valid/ready backpressure.
module pool_unit
    import pool_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int WIN       = 9,
    parameter int AVG_SHIFT = 3,
    parameter int TAG_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [WIN*DATA_W-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int STAGES = clog2(WIN);
    localparam int IW     = DATA_W + STAGES;
    localparam int ROOT   = lvl_off(WIN, STAGES, IW);
    localparam int TOT    = ROOT + IW;

    logic [TOT-1:0]   tree_c;
    logic             vld_c  [STAGES+1];
    logic             mode_c [STAGES+1];
    logic [TAG_W-1:0] tag_c  [STAGES+1];

    logic             stall;
    logic             en;

    logic                    out_valid_q;
    logic [DATA_W-1:0]       out_data_q;
    logic [TAG_W-1:0]        out_tag_q;
    logic [DATA_W-1:0]       result_d;
    logic signed [IW-1:0]    root;
    logic signed [IW-1:0]    shifted;

    // A held result freezes every stage, so one enable drives the whole pipe.
    assign stall    = out_valid_q && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    assign vld_c[0]  = in_valid && en;
    assign mode_c[0] = in_mode;
    assign tag_c[0]  = in_tag;

    for (genvar i = 0; i < WIN; i++) begin : g_sext
        assign tree_c[i*IW +: IW] = IW'($signed(in_data[i*DATA_W +: DATA_W]));
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        pool_tree_level #(
            .N_IN  (lvl_nodes(WIN, k)),
            .IW    (IW),
            .TAG_W (TAG_W)
        ) u_lvl (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .vld_i  (vld_c[k]),
            .mode_i (mode_c[k]),
            .tag_i  (tag_c[k]),
            .data_i (tree_c[lvl_off(WIN, k, IW) +: lvl_nodes(WIN, k)*IW]),
            .vld_o  (vld_c[k+1]),
            .mode_o (mode_c[k+1]),
            .tag_o  (tag_c[k+1]),
            .data_o (tree_c[lvl_off(WIN, k+1, IW) +: lvl_nodes(WIN, k+1)*IW])
        );
    end

    // Finalise: the max already fits DATA_W; the average is floored then clamped.
    assign root    = tree_c[ROOT +: IW];
    assign shifted = root >>> AVG_SHIFT;

    always_comb begin
        result_d = DATA_W'(root);
        if (mode_c[STAGES] == POOL_AVG) begin
            result_d = DATA_W'(sat_s(64'(shifted), DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= vld_c[STAGES];
            if (vld_c[STAGES]) begin
                out_data_q <= result_d;
                out_tag_q  <= tag_c[STAGES];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pool_unit.sv
// Scoreboard bench for pool_unit: a 3x3 instance under handshake, bubble and
// reset traffic, plus 2x2 and 1x1 instances for configuration corners.
module tb_pool_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, in_mode;
    logic [7:0]   in_tag;
    logic [143:0] in_data;
    logic         out_valid, out_ready;
    logic [15:0]  out_data;
    logic [7:0]   out_tag;

    logic         cfg_rdy;
    logic         c4_valid, c4_ready, c4_mode, c4_ovalid;
    logic [7:0]   c4_tag, c4_otag;
    logic [63:0]  c4_data;
    logic [15:0]  c4_odata;
    logic         c1_valid, c1_ready, c1_mode, c1_ovalid;
    logic [7:0]   c1_tag, c1_otag;
    logic [15:0]  c1_data;
    logic [15:0]  c1_odata;

    pool_unit #(.DATA_W(16), .WIN(9), .AVG_SHIFT(3), .TAG_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    pool_unit #(.DATA_W(16), .WIN(4), .AVG_SHIFT(2), .TAG_W(8)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c4_valid), .in_ready(c4_ready), .in_mode(c4_mode),
        .in_tag(c4_tag), .in_data(c4_data),
        .out_valid(c4_ovalid), .out_ready(cfg_rdy),
        .out_data(c4_odata), .out_tag(c4_otag)
    );

    pool_unit #(.DATA_W(16), .WIN(1), .AVG_SHIFT(3), .TAG_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c1_valid), .in_ready(c1_ready), .in_mode(c1_mode),
        .in_tag(c1_tag), .in_data(c1_data),
        .out_valid(c1_ovalid), .out_ready(cfg_rdy),
        .out_data(c1_odata), .out_tag(c1_otag)
    );

    typedef struct {
        logic [15:0] d;
        logic [7:0]  t;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   pops  = 0;
    bit   mon_en = 1'b0;
    int   vals[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: plain integer max/sum, floor division, clamp to 16-bit range.
    function automatic logic [15:0] model(input bit mode, input logic [143:0] d,
                                          input int win, input int sh);
        int s, m, v, q, div;
        s = 0;
        m = -65536;
        for (int i = 0; i < win; i++) begin
            v = int'($signed(d[i*16 +: 16]));
            s = s + v;
            if (v > m) m = v;
        end
        if (!mode) return 16'(m);
        div = 1 << sh;
        q = s / div;
        if (s < 0 && q * div != s) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [143:0] pack_vals(input int n);
        logic [143:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[i*16 +: 16] = 16'(vals[i]);
        return d;
    endfunction

    function automatic logic [143:0] rnd_win();
        logic [143:0] d;
        for (int i = 0; i < 9; i++) d[i*16 +: 16] = 16'($urandom);
        return d;
    endfunction

    task automatic send(input bit mode, input logic [7:0] tag, input logic [143:0] d, input int lat);
        int tries;
        exp_t x;
        tries = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_tag   = tag;
        in_data  = d;
        #1;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            x.d = model(mode, d, 9, 3);
            x.t = tag;
            x.acc = cyc;
            x.lat = lat;
            sbq.push_back(x);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd_win();
        in_mode  = 1'($urandom);
        in_tag   = 8'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = rnd_win();
        in_mode  = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic cfg_beat(input bit sel1, input bit mode, input logic [143:0] d,
                            input int win, input int sh, input int exp_lat, input string nm);
        int n;
        bit seen;
        logic [15:0] od;
        logic [7:0]  ot;
        n = 0;
        seen = 1'b0;
        if (sel1) begin
            c1_valid = 1'b1; c1_mode = mode; c1_tag = 8'h5A; c1_data = d[15:0];
        end else begin
            c4_valid = 1'b1; c4_mode = mode; c4_tag = 8'h5A; c4_data = d[63:0];
        end
        #1;
        chk({nm, "_rdy"}, 32'(sel1 ? c1_ready : c4_ready), 32'd1);
        while (!seen && n < 20) begin
            @(negedge clk);
            #2;
            n++;
            c1_valid = 1'b0;
            c4_valid = 1'b0;
            seen = sel1 ? c1_ovalid : c4_ovalid;
        end
        od = sel1 ? c1_odata : c4_odata;
        ot = sel1 ? c1_otag : c4_otag;
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk({nm, "_data"}, 32'(od), 32'(model(mode, d, win, sh)));
        chk({nm, "_tag"}, 32'(ot), 32'h5A);
        @(negedge clk);
    endtask

    // Output monitor: decides each transfer half a cycle before the edge.
    always @(negedge clk) begin
        #2;
        if (rst_n && mon_en) begin
            if (out_ready) chk("in_ready_hi", 32'(in_ready), 32'd1);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("extra_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sbq[0];
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        pops++;
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_tag", 32'(out_tag), 32'(e.t));
                        if (e.lat >= 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end else begin
                        chk("stall_data", 32'(out_data), 32'(e.d));
                        chk("stall_tag", 32'(out_tag), 32'(e.t));
                        chk("stall_in_ready", 32'(in_ready), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        int p0;
        rst_n = 1'b0; out_ready = 1'b1; cfg_rdy = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_tag = '0; in_data = '0;
        c4_valid = 1'b0; c4_mode = 1'b0; c4_tag = '0; c4_data = '0;
        c1_valid = 1'b0; c1_mode = 1'b0; c1_tag = '0; c1_data = '0;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single max beat with the most negative element in the window.
        vals = '{-5, 3, -32768, 100, 7, 100, 0, -1, 99};
        send(1'b0, 8'h21, pack_vals(9), 5);

        // Average rounding and saturation corners, back to back.
        vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        send(1'b1, 8'h30, pack_vals(9), 5);
        vals = '{-1, -2, -3, -4, -5, -6, -7, -8, -9};
        send(1'b1, 8'h31, pack_vals(9), 5);
        vals = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        send(1'b1, 8'h32, pack_vals(9), 5);
        vals = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        send(1'b1, 8'h33, pack_vals(9), 5);
        send(1'b0, 8'h34, pack_vals(9), 5);
        drain();

        // Bubbles: valid pattern 1,0,0,1,1.
        send(1'b0, 8'h40, rnd_win(), 5);
        idle(2);
        send(1'b1, 8'h41, rnd_win(), 5);
        send(1'b0, 8'h42, rnd_win(), 5);
        drain();

        // Backpressure: 8 mixed-mode beats with a 3-cycle out_ready drop.
        p0 = pops;
        fork
            begin
                for (int t = 0; t < 8; t++) send(t[0], 8'(t), rnd_win(), -1);
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(pops - p0), 32'd8);

        // Reset with three beats in flight.
        send(1'b0, 8'h50, rnd_win(), -1);
        send(1'b1, 8'h51, rnd_win(), -1);
        send(1'b0, 8'h52, rnd_win(), -1);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);
        idle(10);
        send(1'b1, 8'h60, rnd_win(), 5);
        drain();
        chk("final_empty", 32'(sbq.size()), 32'd0);

        // Other window sizes.
        vals = '{4, 4, 4, 5, 0, 0, 0, 0, 0};
        cfg_beat(1'b0, 1'b1, pack_vals(4), 4, 2, 3, "w4_avg");
        vals = '{-3, -9, 2, -1, 0, 0, 0, 0, 0};
        cfg_beat(1'b0, 1'b0, pack_vals(4), 4, 2, 3, "w4_max");
        vals = '{-7, 0, 0, 0, 0, 0, 0, 0, 0};
        cfg_beat(1'b1, 1'b0, pack_vals(1), 1, 3, 1, "w1_max");
        cfg_beat(1'b1, 1'b1, pack_vals(1), 1, 3, 1, "w1_avg");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
